sd_cmd_seq: RTL

Command sequencer for the RK8E SD card path. It drives the byte-level SPI engine (sdspi) through its spiOP/spiTXD/spiDONE handshake and executes one complete SD SPI-mode command transaction. The transaction is: assert CS, send a pre-fill byte, send the 6-byte command frame, poll for R1, optionally capture 4 trailing response bytes, send a trailing fill byte, then optionally release CS. It sits between the RK8E disk state machine and sdspi. It frees the disk controller from byte-level sequencing.

---
 rtl/sd_cmd_seq_pkg.sv | 32 +++
 rtl/sd_crc7.sv | 39 +++
 rtl/sd_cmd_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_seq_pkg.sv
// Shared types for the RK8E SD card path.
//   sdspi_types : operation codes understood by the byte-level SPI engine (sdspi)
//   sd_types    : SD byte type and SPI-mode command/response constants
package sdspi_types;

    typedef enum logic [2:0] {
        spiNOP  = 3'd0,
        spiCSL  = 3'd1,
        spiCSH  = 3'd2,
        spiFAST = 3'd3,
        spiSLOW = 3'd4,
        spiTR   = 3'd5
    } spiOP_t;

endpackage

package sd_types;

    typedef logic [7:0] sdBYTE_t;

    // Every command frame begins with start bit 0 and transmission bit 1
    localparam logic [1:0] SD_START_BITS = 2'b01;

    // Idle level of MOSI; sent whenever the card only needs clocks
    localparam sdBYTE_t SD_FILL = 8'hFF;

    // R1 response bit positions
    localparam int R1_IDLE        = 0;
    localparam int R1_ILLEGAL_CMD = 2;
    localparam int R1_CRC_ERR     = 3;

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator (x^7 + x^3 + 1, init 0), MSB of each byte first.
// Only instantiated when SD_CRC7_GEN_EN is defined.
module sd_crc7
    import sd_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  sdBYTE_t    din,
    output logic [6:0] crc
);

    logic [6:0] crcNext;

    // Fold all eight bits of din into the running remainder
    always_comb begin
        crcNext = crc;
        for (int i = 7; i >= 0; i--) begin
            if (crcNext[6] ^ din[i]) begin
                crcNext = {crcNext[5:0], 1'b0} ^ 7'h09;
            end else begin
                crcNext = {crcNext[5:0], 1'b0};
            end
        end
    end

    // Remainder register: clear at frame start, accumulate on each enabled byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= 7'd0;
        end else if (clr) begin
            crc <= 7'd0;
        end else if (en) begin
            crc <= crcNext;
        end
    end

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer for the RK8E disk path.
// Runs one complete command transaction on sdspi: CS low, fill bytes, 6-byte
// frame, R1 poll, optional 4-byte long response, Nrc fill byte, optional CS high.
// Build option: SD_CRC7_GEN_EN -- generate the frame CRC7 locally instead of
// using cmd_crc.
//
// sdspi handshake: spiOP is non-NOP for exactly one cycle (the issue cycle).
// For spiTR the sequencer then waits for spiDONE, sampling spiRXD in that
// cycle, and spiTXD holds the byte from issue until spiDONE. For spiCSL/spiCSH
// it waits exactly one further cycle and expects no spiDONE.
module sd_cmd_seq
    import sd_types::*, sdspi_types::*;
#(
    parameter int NCR_MAX   = 8,
    parameter int PRE_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        rsp_long,
    input  logic        keep_cs,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output sdBYTE_t     r1,
    output logic [31:0] rsp_data,
    output spiOP_t      spiOP,
    output sdBYTE_t     spiTXD,
    input  sdBYTE_t     spiRXD,
    input  logic        spiDONE
);

    typedef enum logic [3:0] {
        IDLE, CSL, PRE, CMD, NCR, RSP, TRAIL, CSH, FIN
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PRE_BYTES - 1);
    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);
    localparam logic [7:0] CMD_LAST = 8'd5;
    localparam logic [7:0] RSP_LAST = 8'd3;

    state_t      state, nextState;
    logic        pending;      // operation issued, waiting for its completion
    logic [7:0]  cnt;          // byte index within the current state
    logic [5:0]  idxQ;
    logic [31:0] argQ;
    logic        rspLongQ;
    logic        keepCsQ;
    sdBYTE_t     frameByte;
    sdBYTE_t     crcByte;

    logic isTr, isCs, issue, xfer, csWait, startAccept;

    assign isTr        = (state == PRE) || (state == CMD) || (state == NCR) ||
                         (state == RSP) || (state == TRAIL);
    assign isCs        = (state == CSL) || (state == CSH);
    assign issue       = (isTr || isCs) && !pending;
    assign xfer        = isTr && pending && spiDONE;
    assign csWait      = isCs && pending;
    assign startAccept = (state == IDLE) && cmd_start;

`ifdef SD_CRC7_GEN_EN
    logic [6:0] crcOut;

    sd_crc7 u_crc7 (
        .clk (clk),
        .rst (rst),
        .clr (startAccept),
        .en  ((state == CMD) && issue && (cnt < CMD_LAST)),
        .din (frameByte),
        .crc (crcOut)
    );

    assign crcByte = {crcOut, 1'b1};
`else
    logic [6:0] crcQ;

    assign crcByte = {crcQ, 1'b1};

    // Hold the caller's CRC7 for the duration of the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crcQ <= 7'd0;
        end else if (startAccept) begin
            crcQ <= cmd_crc;
        end
    end
`endif

    // State register with per-state byte counter and issue/wait flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            pending <= 1'b0;
        end else begin
            state <= nextState;
            if (state != nextState) begin
                cnt     <= 8'd0;
                pending <= 1'b0;
            end else begin
                if (xfer) begin
                    cnt <= cnt + 8'd1;
                end
                if (issue) begin
                    pending <= 1'b1;
                end else if (xfer) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    // Next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (cmd_start) nextState = CSL;
            CSL:   if (csWait) nextState = PRE;
            PRE:   if (xfer && cnt == PRE_LAST) nextState = CMD;
            CMD:   if (xfer && cnt == CMD_LAST) nextState = NCR;
            NCR: begin
                if (xfer) begin
                    if (!spiRXD[7]) begin
                        nextState = (rspLongQ && spiRXD[6:1] == 6'd0) ? RSP : TRAIL;
                    end else if (cnt == NCR_LAST) begin
                        nextState = TRAIL;
                    end
                end
            end
            RSP:   if (xfer && cnt == RSP_LAST) nextState = TRAIL;
            TRAIL: if (xfer) nextState = (keepCsQ && !err_timeout) ? FIN : CSH;
            CSH:   if (csWait) nextState = FIN;
            FIN:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs toward sdspi and the disk controller
    always_comb begin
        case (cnt)
            8'd0:    frameByte = {SD_START_BITS, idxQ};
            8'd1:    frameByte = argQ[31:24];
            8'd2:    frameByte = argQ[23:16];
            8'd3:    frameByte = argQ[15:8];
            8'd4:    frameByte = argQ[7:0];
            default: frameByte = crcByte;
        endcase

        spiTXD = (state == CMD) ? frameByte : SD_FILL;
        spiOP  = spiNOP;
        if (issue) begin
            if (state == CSL)      spiOP = spiCSL;
            else if (state == CSH) spiOP = spiCSH;
            else                   spiOP = spiTR;
        end

        busy = (state != IDLE) && (state != FIN);
        done = (state == FIN);
    end

    // Command latch and captured results; results hold until the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idxQ        <= 6'd0;
            argQ        <= 32'd0;
            rspLongQ    <= 1'b0;
            keepCsQ     <= 1'b0;
            err_timeout <= 1'b0;
            r1          <= SD_FILL;
            rsp_data    <= 32'd0;
        end else begin
            if (startAccept) begin
                idxQ        <= cmd_idx;
                argQ        <= cmd_arg;
                rspLongQ    <= rsp_long;
                keepCsQ     <= keep_cs;
                err_timeout <= 1'b0;
                r1          <= SD_FILL;
            end
            if (state == NCR && xfer) begin
                if (!spiRXD[7]) begin
                    r1 <= spiRXD;
                end else if (cnt == NCR_LAST) begin
                    err_timeout <= 1'b1;
                    r1          <= SD_FILL;
                end
            end
            if (state == RSP && xfer) begin
                rsp_data <= {rsp_data[23:0], spiRXD};
            end
        end
    end

endmodule
